// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote_collector block.
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DECIDE  = 2'd2
    } vote_state_t;

    // Width needed to hold a tally of 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vote_idle_timer.sv
// Idle down-counter for vote_collector: reloads on clr, counts while run, pulses expire
// on the TIMEOUT-th consecutive run cycle without a clr.
module vote_idle_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expire
);
    localparam int TO = (TIMEOUT < 1) ? 1 : TIMEOUT;
    localparam int TW = $clog2(TO + 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= TW'(TO);
        end else if (clr) begin
            count <= TW'(TO);
        end else if (run && count > TW'(1)) begin
            count <= count - TW'(1);
        end
    end

    // A clr in the expiry cycle is an accept, which takes priority over the abort.
    assign expire = run && !clr && (count == TW'(1));

endmodule

// File: rtl/vote_collector.sv
// Sequential ballot collector: tallies N_VOTERS serial ballots and registers the majority on led.
// Optional idle abort is built when VOTE_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start; yes_count and led hold the last round
// COLLECT | vote_ready high, accepting one ballot per vote_valid
// DECIDE  | one cycle; next edge loads led and pulses done
module vote_collector
    import vote_pkg::*;
#(
    parameter int  N_VOTERS = 5,
    parameter int  TIMEOUT  = 1000,
    localparam int CNT_W    = cnt_w(N_VOTERS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vote_valid,
    input  logic             vote_bit,
    output logic             vote_ready,
    output logic             busy,
    output logic [CNT_W-1:0] yes_count,
    output logic             led,
    output logic             done,
    output logic             timeout
);
    if (N_VOTERS < 1 || N_VOTERS > 255 || TIMEOUT < 1) begin : g_param_check
        $error("vote_collector: N_VOTERS must be 1..255 and TIMEOUT at least 1");
    end

    vote_state_t      state, state_nx;
    logic [CNT_W-1:0] ballots;
    logic             accept;
    logic             last_ballot;
    logic             start_round;
    logic             expire;
    logic [CNT_W:0]   yes_twice;
    logic             majority;

    assign start_round = (state == IDLE) && start;
    assign accept      = (state == COLLECT) && vote_valid;
    assign last_ballot = accept && (ballots == CNT_W'(N_VOTERS - 1));

    // One extra bit so doubling the tally cannot wrap.
    assign yes_twice = {yes_count, 1'b0};
    assign majority  = yes_twice > (CNT_W + 1)'(N_VOTERS);

`ifdef VOTE_TIMEOUT_EN
    logic timeout_q;

    vote_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start_round || accept),
        .run    (state == COLLECT),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= expire;
        end
    end

    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = COLLECT;
            COLLECT: begin
                if (last_ballot) begin
                    state_nx = DECIDE;
                end else if (expire) begin
                    state_nx = IDLE;
                end
            end
            DECIDE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ballots   <= '0;
            yes_count <= '0;
            led       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == DECIDE) || expire;
            if (start_round) begin
                ballots   <= '0;
                yes_count <= '0;
            end else if (accept) begin
                ballots   <= ballots + CNT_W'(1);
                yes_count <= yes_count + CNT_W'(vote_bit);
            end
            if (state == DECIDE) begin
                led <= majority;
            end
        end
    end

    assign vote_ready = (state == COLLECT);
    assign busy       = (state != IDLE);

endmodule
